hex_display_driver: RTL and testbench

HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

---
 rtl/hex_display_driver.sv | 107 ++++++++++
 tb/tb_hex_display_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hex_display_driver.sv
// Multi-digit 7-segment hex driver: registered static per-digit segments plus a
// time-multiplexed seg/an bus, with leading-zero blanking, per-digit enables and blink.
module hex_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      blank_lz,
  input  logic                      blink_en,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  output logic [7*NUM_DIGITS-1:0]   hex,
  output logic [6:0]                seg,
  output logic [NUM_DIGITS-1:0]     an
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit AL = (ACTIVE_LOW != 0);
  localparam logic [6:0] BLANK = AL ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AL ? '1 : '0;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'h40;  4'h1: c = 7'h79;  4'h2: c = 7'h24;  4'h3: c = 7'h30;
      4'h4: c = 7'h19;  4'h5: c = 7'h12;  4'h6: c = 7'h02;  4'h7: c = 7'h78;
      4'h8: c = 7'h00;  4'h9: c = 7'h10;  4'hA: c = 7'h08;  4'hB: c = 7'h03;
      4'hC: c = 7'h46;  4'hD: c = 7'h21;  4'hE: c = 7'h06;  default: c = 7'h0E;
    endcase
    return AL ? c : ~c;
  endfunction

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    blink_wrap, scan_wrap, nz_above, blank;
  int unsigned             d;

  always_comb begin
    value_d       = load ? value : value_q;
    blink_wrap    = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q ^ blink_wrap;
    scan_wrap     = (scan_cnt_q == SW'(SCAN_DIV - 1));
    scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + SW'(1);
    idx_d         = idx_q;
    if (scan_wrap)
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);

    // Walk from the top digit down so nz_above means "this or a higher nibble is nonzero".
    // Blink uses the next phase so the blanked window lines up with the phase itself.
    nz_above = 1'b0;
    blank    = 1'b0;
    d        = 0;
    hex_d    = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      d        = NUM_DIGITS - 1 - j;
      nz_above = nz_above | (|value_q[4*d +: 4]);
      blank    = ~digit_en[d] | (blink_en & blink_phase_d) | (blank_lz & (d != 0) & ~nz_above);
      hex_d[7*d +: 7] = blank ? BLANK : seg_code(value_q[4*d +: 4]);
    end

    seg_d = BLANK;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (idx_d == IW'(i)) seg_d = hex_d[7*i +: 7];
    an_d = NUM_DIGITS'(1) << idx_d;
    if (AL) an_d = ~an_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      hex_q         <= {NUM_DIGITS{BLANK}};
      seg_q         <= BLANK;
      an_q          <= AN_OFF;
    end else begin
      value_q       <= value_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      hex_q         <= hex_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign hex = hex_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Scoreboard bench for hex_display_driver: four parameterisations share one stimulus
// stream; a reference model queues expectations that a negedge monitor compares.
module tb_hex_display_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld  = 1'b0;
  logic [23:0] val = '0;
  logic        blz = 1'b0;
  logic        ben = 1'b0;
  logic [5:0]  den = '1;

  logic [41:0] hex_a, hex_c;
  logic [27:0] hex_b;
  logic [6:0]  hex_d;
  logic [6:0]  seg_a, seg_b, seg_c, seg_d;
  logic [5:0]  an_a, an_c;
  logic [3:0]  an_b;
  logic [0:0]  an_d;

  always #5 clk = ~clk;

  hex_display_driver #(.NUM_DIGITS(6), .BLINK_DIV(4), .SCAN_DIV(3), .ACTIVE_LOW(1)) u_a (
    .clk(clk), .reset(rst), .load(ld), .value(val), .blank_lz(blz), .blink_en(ben),
    .digit_en(den), .hex(hex_a), .seg(seg_a), .an(an_a));
  hex_display_driver #(.NUM_DIGITS(4), .BLINK_DIV(3), .SCAN_DIV(2), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .reset(rst), .load(ld), .value(val[15:0]), .blank_lz(blz), .blink_en(ben),
    .digit_en(den[3:0]), .hex(hex_b), .seg(seg_b), .an(an_b));
  hex_display_driver #(.NUM_DIGITS(6), .BLINK_DIV(1), .SCAN_DIV(1), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .reset(rst), .load(ld), .value(val), .blank_lz(blz), .blink_en(ben),
    .digit_en(den), .hex(hex_c), .seg(seg_c), .an(an_c));
  hex_display_driver #(.NUM_DIGITS(1), .BLINK_DIV(2), .SCAN_DIV(1), .ACTIVE_LOW(1)) u_d (
    .clk(clk), .reset(rst), .load(ld), .value(val[3:0]), .blank_lz(blz), .blink_en(ben),
    .digit_en(den[0:0]), .hex(hex_d), .seg(seg_d), .an(an_d));

  logic [55:0] act_hex [4];
  logic [6:0]  act_seg [4];
  logic [7:0]  act_an  [4];
  assign act_hex[0] = 56'(hex_a);  assign act_seg[0] = seg_a;  assign act_an[0] = 8'(an_a);
  assign act_hex[1] = 56'(hex_b);  assign act_seg[1] = seg_b;  assign act_an[1] = 8'(an_b);
  assign act_hex[2] = 56'(hex_c);  assign act_seg[2] = seg_c;  assign act_an[2] = 8'(an_c);
  assign act_hex[3] = 56'(hex_d);  assign act_seg[3] = seg_d;  assign act_an[3] = 8'(an_d);

  function automatic int p_nd(int k); return (k == 1) ? 4 : (k == 3) ? 1 : 6; endfunction
  function automatic int p_bd(int k); return (k == 0) ? 4 : (k == 1) ? 3 : (k == 2) ? 1 : 2; endfunction
  function automatic int p_sd(int k); return (k == 0) ? 3 : (k == 1) ? 2 : 1; endfunction
  function automatic bit p_al(int k); return (k != 2); endfunction

  function automatic logic [6:0] ref_code(int n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  typedef struct packed {
    logic [3:0][55:0] hex;
    logic [3:0][6:0]  seg;
    logic [3:0][7:0]  an;
  } exp_t;
  exp_t sbq [$];

  int m_val [4], m_bc [4], m_ph [4], m_sc [4], m_idx [4];
  int n_pass = 0, n_total = 0;

  task automatic check(string name, int k, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s[u%0d] t=%0t: got %h expected %h", name, k, $time, act, exp);
    else n_pass++;
  endtask

  // Reference: all state advanced from arithmetic on counts; hex uses the value held before this edge.
  task automatic model_step();
    exp_t e;
    logic [55:0] h;
    logic [6:0] c, blank7;
    int nd, msd, nib, mask;
    bit dark;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      nd = p_nd(k);
      mask = (1 << nd) - 1;
      blank7 = p_al(k) ? 7'h7F : 7'h00;
      h = '0;
      if (rst) begin
        m_val[k] = 0; m_bc[k] = 0; m_ph[k] = 0; m_sc[k] = 0; m_idx[k] = 0;
        for (int i = 0; i < nd; i++) h[7*i +: 7] = blank7;
        e.hex[k] = h;
        e.seg[k] = blank7;
        e.an[k]  = p_al(k) ? 8'(mask) : 8'h00;
      end else begin
        m_bc[k] = (m_bc[k] + 1) % p_bd(k);
        if (m_bc[k] == 0) m_ph[k] = 1 - m_ph[k];
        m_sc[k] = (m_sc[k] + 1) % p_sd(k);
        if (m_sc[k] == 0) m_idx[k] = (m_idx[k] + 1) % nd;
        msd = 0;
        for (int i = 0; i < nd; i++) if (((m_val[k] >> (4*i)) & 15) != 0) msd = i;
        for (int i = 0; i < nd; i++) begin
          nib  = (m_val[k] >> (4*i)) & 15;
          dark = !den[i] || (ben && m_ph[k] == 1) || (blz && i > msd);
          c = dark ? 7'h7F : ref_code(nib);
          h[7*i +: 7] = p_al(k) ? c : ~c;
        end
        e.hex[k] = h;
        e.seg[k] = h[7*m_idx[k] +: 7];
        e.an[k]  = 8'(1 << m_idx[k]);
        if (p_al(k)) e.an[k] = ~e.an[k] & 8'(mask);
        if (ld) m_val[k] = int'(val) & ((1 << (4*nd)) - 1);
      end
    end
    sbq.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      for (int k = 0; k < 4; k++) begin
        check("hex", k, 64'(act_hex[k]), 64'(e.hex[k]));
        check("seg", k, 64'(act_seg[k]), 64'(e.seg[k]));
        check("an",  k, 64'(act_an[k]),  64'(e.an[k]));
      end
    end
  end

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_ZERO  = {6{7'h40}};
  localparam logic [41:0] EXP_LZ    = {7'h7F, 7'h7F, 7'h08, 7'h40, 7'h0E, 7'h30};
  localparam logic [41:0] EXP_EN    = {7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00};

  initial begin
    // Reset wins over a simultaneous load of all-F.
    rst = 1'b1; ld = 1'b1; val = 24'hFFFFFF; blz = 1'b0; ben = 1'b0; den = '1;
    cycle();
    cycle();
    check("reset_blank", 0, 64'(hex_a), 64'(ALL_BLANK));
    rst = 1'b0; ld = 1'b0;
    cycle();
    check("release_zero", 0, 64'(hex_a), 64'(ALL_ZERO));

    ld = 1'b1; val = 24'h00A0F3; blz = 1'b1;
    cycle();
    ld = 1'b0;
    cycle();
    check("lz_blank", 0, 64'(hex_a), 64'(EXP_LZ));

    ld = 1'b1; val = 24'h888888; blz = 1'b0; den = 6'b101010;
    cycle();
    ld = 1'b0;
    cycle();
    check("digit_en_ahigh", 2, 64'(hex_c), 64'(EXP_EN));

    rst = 1'b1; den = '1; ben = 1'b1;
    cycle();
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      cycle();
      check("blink", 0, 64'(hex_a), 64'(((t / 4) % 2 == 1) ? ALL_BLANK : ALL_ZERO));
      check("scan_an", 1, 64'(an_b), 64'(4'hF & ~(4'h1 << ((t / 2) % 4))));
    end

    ben = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 6; i++)
        val[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blz = ~blz;
      if ($urandom_range(0, 19) == 0) ben = ~ben;
      den = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F;
      cycle();
    end

    rst = 1'b0; ld = 1'b0;
    cycle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
